// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padding front end.
package sha256_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    PAD  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int         BLOCK_BYTES = 64;
  localparam int         LEN_POS     = 56;
  localparam logic [7:0] PAD_MARKER  = 8'h80;

endpackage

// File: rtl/sha256_block_buf.sv
// 64-byte block buffer: one byte write port, whole block read out flat with
// byte 0 in the most significant position so word 0 holds bytes 0..3.
module sha256_block_buf
  import sha256_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [5:0]   i_addr,
  input  logic [7:0]   i_data,
  input  logic         i_we,
  output logic [511:0] o_data
);

  logic [7:0] mem [BLOCK_BYTES];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < BLOCK_BYTES; i++) mem[i] <= 8'h00;
    end else if (i_we) begin
      mem[i_addr] <= i_data;
    end
  end

  always_comb begin
    o_data = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) o_data[511 - 8*i -: 8] = mem[i];
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// Byte-stream to padded 512-bit block converter (0x80 marker, zero fill,
// 64-bit big-endian bit length), emitting an extra block when needed.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_BYTES_W = 61
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_byte,
  input  logic        i_valid,
  input  logic        i_last,
  input  logic        i_empty,
  output logic        o_ready,
  output logic [31:0] o_w0,
  output logic [31:0] o_w1,
  output logic [31:0] o_w2,
  output logic [31:0] o_w3,
  output logic [31:0] o_w4,
  output logic [31:0] o_w5,
  output logic [31:0] o_w6,
  output logic [31:0] o_w7,
  output logic [31:0] o_w8,
  output logic [31:0] o_w9,
  output logic [31:0] o_w10,
  output logic [31:0] o_w11,
  output logic [31:0] o_w12,
  output logic [31:0] o_w13,
  output logic [31:0] o_w14,
  output logic [31:0] o_w15,
  output logic        o_block_valid,
  output logic        o_block_last,
  input  logic        i_block_ready,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: a byte moves when i_valid & o_ready, a block moves when
  // o_block_valid & i_block_ready; both ready/valid outputs decode only state_q.

  localparam logic [5:0] LEN_IDX  = 6'(LEN_POS);
  localparam logic [5:0] LAST_IDX = 6'(BLOCK_BYTES - 1);

  state_e                 state_q, state_d;
  logic [5:0]             idx_q, idx_d;
  logic [LEN_BYTES_W-1:0] count_q, count_d;
  logic                   pend_q, pend_d;     // marker still to be written
  logic                   mwr_q, mwr_d;       // marker already written
  logic                   lsel_q, lsel_d;     // length field goes in this block
  logic                   final_q, final_d;
  logic                   last_q, last_d;     // end of message has been seen

  logic                   we;
  logic [7:0]             wdata;
  logic                   sel_eff;
  logic [63:0]            bit_len;
  logic [7:0]             len_byte;
  logic [511:0]           blk;

  assign bit_len  = 64'({count_q, 3'b000});
  assign len_byte = bit_len[{~idx_q[2:0], 3'b000} +: 8];
  // At the length position itself the decision rests on whether the marker
  // went out in an earlier cycle; afterwards the latched decision holds.
  assign sel_eff  = (idx_q == LEN_IDX) ? mwr_q : lsel_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= LOAD;
      idx_q   <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
      mwr_q   <= 1'b0;
      lsel_q  <= 1'b0;
      final_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      mwr_q   <= mwr_d;
      lsel_q  <= lsel_d;
      final_q <= final_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    pend_d  = pend_q;
    mwr_d   = mwr_q;
    lsel_d  = lsel_q;
    final_d = final_q;
    last_d  = last_q;
    we      = 1'b0;
    wdata   = 8'h00;
    case (state_q)
      LOAD: begin
        if (i_valid) begin
          if (i_last && i_empty) begin
            last_d  = 1'b1;
            pend_d  = 1'b1;
            state_d = PAD;
          end else begin
            we      = 1'b1;
            wdata   = i_byte;
            count_d = count_q + LEN_BYTES_W'(1);
            if (i_last) begin
              last_d = 1'b1;
              pend_d = 1'b1;
            end
            if (idx_q == LAST_IDX) begin
              state_d = OUT;
              final_d = 1'b0;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 6'd1;
              if (i_last) state_d = PAD;
            end
          end
        end
      end
      PAD: begin
        we = 1'b1;
        if (pend_q) begin
          wdata  = PAD_MARKER;
          pend_d = 1'b0;
          mwr_d  = 1'b1;
        end else if (idx_q >= LEN_IDX && sel_eff) begin
          wdata = len_byte;
        end
        if (idx_q == LEN_IDX) lsel_d = mwr_q;
        if (idx_q == LAST_IDX) begin
          state_d = OUT;
          final_d = sel_eff;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      OUT: begin
        if (i_block_ready) begin
          idx_d = '0;
          if (final_q) begin
            state_d = LOAD;
            count_d = '0;
            pend_d  = 1'b0;
            mwr_d   = 1'b0;
            lsel_d  = 1'b0;
            final_d = 1'b0;
            last_d  = 1'b0;
          end else if (last_q) begin
            state_d = PAD;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  sha256_block_buf u_buf (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_addr  (idx_q),
    .i_data  (wdata),
    .i_we    (we),
    .o_data  (blk)
  );

  assign o_ready       = (state_q == LOAD);
  assign o_block_valid = (state_q == OUT);
  assign o_block_last  = (state_q == OUT) && final_q;
  assign o_dbg_state   = state_q;

  assign o_w0  = blk[511:480];
  assign o_w1  = blk[479:448];
  assign o_w2  = blk[447:416];
  assign o_w3  = blk[415:384];
  assign o_w4  = blk[383:352];
  assign o_w5  = blk[351:320];
  assign o_w6  = blk[319:288];
  assign o_w7  = blk[287:256];
  assign o_w8  = blk[255:224];
  assign o_w9  = blk[223:192];
  assign o_w10 = blk[191:160];
  assign o_w11 = blk[159:128];
  assign o_w12 = blk[127:96];
  assign o_w13 = blk[95:64];
  assign o_w14 = blk[63:32];
  assign o_w15 = blk[31:0];

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: known padding vectors, back-pressure
// hold, and mid-message reset recovery.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_byte;
  logic        i_valid, i_last, i_empty;
  logic        o_ready;
  logic [31:0] w [16];
  logic        o_block_valid, o_block_last;
  logic        i_block_ready;
  logic [1:0]  o_dbg_state;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int t_start = 0;
  int lat;
  logic [7:0]  msg_q [$];
  logic [31:0] snap0, snap15;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha256_msg_padder dut (
    .i_clk(clk), .i_reset(rst), .i_byte(i_byte), .i_valid(i_valid),
    .i_last(i_last), .i_empty(i_empty), .o_ready(o_ready),
    .o_w0(w[0]), .o_w1(w[1]), .o_w2(w[2]), .o_w3(w[3]),
    .o_w4(w[4]), .o_w5(w[5]), .o_w6(w[6]), .o_w7(w[7]),
    .o_w8(w[8]), .o_w9(w[9]), .o_w10(w[10]), .o_w11(w[11]),
    .o_w12(w[12]), .o_w13(w[13]), .o_w14(w[14]), .o_w15(w[15]),
    .o_block_valid(o_block_valid), .o_block_last(o_block_last),
    .i_block_ready(i_block_ready), .o_dbg_state(o_dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_block(input string tag, input logic [31:0] e0, input logic [31:0] fill,
                             input logic [31:0] e13, input logic [31:0] e14,
                             input logic [31:0] e15, input logic elast);
    logic [31:0] e;
    for (int i = 0; i < 16; i++) begin
      e = (i == 0) ? e0 : (i == 13) ? e13 : (i == 14) ? e14 : (i == 15) ? e15 : fill;
      chk($sformatf("%s w%0d", tag, i), w[i], e);
    end
    chk({tag, " last"}, {31'b0, o_block_last}, {31'b0, elast});
  endtask

  task automatic fill_msg(input int n, input logic [7:0] v);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(v);
  endtask

  task automatic send_msg();
    for (int i = 0; i < msg_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) t_start = cyc;
      i_byte  = msg_q[i];
      i_valid = 1'b1;
      i_last  = (i == msg_q.size() - 1);
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic wait_block(input string tag, output int l);
    int n;
    n = 0;
    while (!o_block_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " block_valid"}, {31'b0, o_block_valid}, 32'd1);
    l = cyc - t_start;
  endtask

  task automatic take_block();
    i_block_ready = 1'b1;
    @(negedge clk);
    i_block_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_byte = 8'h00; i_valid = 1'b0; i_last = 1'b0;
    i_empty = 1'b0; i_block_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst ready", {31'b0, o_ready}, 32'd1);
    chk("rst bvalid", {31'b0, o_block_valid}, 32'd0);
    chk("rst blast", {31'b0, o_block_last}, 32'd0);
    chk("rst w0", w[0], 32'h0);
    chk("rst w15", w[15], 32'h0);
    chk("rst state", {30'b0, o_dbg_state}, 32'd0);
    rst = 1'b0;

    // "abc"
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg();
    wait_block("abc", lat);
    chk("abc latency", lat, 32'd64);
    check_block("abc", 32'h61626380, 32'h0, 32'h0, 32'h0, 32'h00000018, 1'b1);
    take_block();
    chk("abc ready after hs", {31'b0, o_ready}, 32'd1);

    // empty message
    @(negedge clk);
    t_start = cyc;
    i_byte = 8'h55; i_valid = 1'b1; i_last = 1'b1; i_empty = 1'b1;
    @(negedge clk);
    i_valid = 1'b0; i_last = 1'b0; i_empty = 1'b0;
    wait_block("empty", lat);
    chk("empty latency", lat, 32'd65);
    check_block("empty", 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    take_block();

    // 55 zero bytes: fits in one block
    fill_msg(55, 8'h00);
    send_msg();
    wait_block("z55", lat);
    check_block("z55", 32'h0, 32'h0, 32'h00000080, 32'h0, 32'h000001B8, 1'b1);
    take_block();

    // 56 zero bytes: length spills into a second block
    fill_msg(56, 8'h00);
    send_msg();
    wait_block("z56 b1", lat);
    check_block("z56 b1", 32'h0, 32'h0, 32'h0, 32'h80000000, 32'h0, 1'b0);
    take_block();
    chk("z56 ready in pad", {31'b0, o_ready}, 32'd0);
    wait_block("z56 b2", lat);
    check_block("z56 b2", 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001C0, 1'b1);
    take_block();

    // 64 bytes of 0xFF: full data block, then marker+length block
    fill_msg(64, 8'hFF);
    send_msg();
    wait_block("ff64 b1", lat);
    check_block("ff64 b1", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFF, 1'b0);
    take_block();
    wait_block("ff64 b2", lat);
    check_block("ff64 b2", 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h00000200, 1'b1);
    take_block();

    // back-pressure on the "abc" block
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg();
    wait_block("bp", lat);
    snap0  = w[0];
    snap15 = w[15];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp hold w0 %0d", i), w[0], 32'h61626380);
      chk($sformatf("bp hold w15 %0d", i), w[15], 32'h00000018);
      chk($sformatf("bp hold last %0d", i), {31'b0, o_block_last}, 32'd1);
      chk($sformatf("bp hold valid %0d", i), {31'b0, o_block_valid}, 32'd1);
      chk($sformatf("bp hold ready %0d", i), {31'b0, o_ready}, 32'd0);
    end
    chk("bp snap w0", snap0, 32'h61626380);
    chk("bp snap w15", snap15, 32'h00000018);
    take_block();

    // reset in the middle of a 20-byte message
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      i_byte = 8'(8'hA0 + i); i_valid = 1'b1; i_last = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    i_byte = 8'hAA;
    @(negedge clk);
    chk("midrst bvalid", {31'b0, o_block_valid}, 32'd0);
    chk("midrst ready", {31'b0, o_ready}, 32'd1);
    chk("midrst w0", w[0], 32'h0);
    rst = 1'b0;
    i_valid = 1'b0;

    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg();
    wait_block("abc2", lat);
    chk("abc2 latency", lat, 32'd64);
    check_block("abc2", 32'h61626380, 32'h0, 32'h0, 32'h0, 32'h00000018, 1'b1);
    take_block();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Front end of the SHA-256 datapath: accepts a message as a byte stream and emits padded 512-bit blocks as sixteen big-endian 32-bit words, w0 through w15. These words feed the message-schedule stage directly. The block performs FIPS 180-4 padding: a 0x80 marker, zero fill, and the 64-bit message bit length. It emits an extra block when the length does not fit, and back-pressures the byte source while padding or while a block is held.

## Interface
Parameters:
- LEN_BYTES_W, default 61: width of the message byte counter; the bit length is {count, 3'b000} zero-extended to 64 bits.

Ports:
- i_clk, input, 1: single clock; all logic on the rising edge.
- i_reset, input, 1: synchronous, active-high reset.
- i_byte, input, 8: message byte.
- i_valid, input, 1: i_byte is valid.
- i_last, input, 1: qualifies i_valid; this is the final byte.
- i_empty, input, 1: qualifies i_valid & i_last; zero-length message, i_byte ignored.
- o_ready, output, 1: byte accepted on a cycle where i_valid & o_ready.
- o_w0 … o_w15, output, 32 each: block words, big-endian; o_w0 = bytes 0..3.
- o_block_valid, output, 1: a complete block is presented.
- o_block_last, output, 1: presented block is the final block of the message.
- i_block_ready, input, 1: consumer takes the block on o_block_valid & i_block_ready.

## Operation
- State machine states:
  - LOAD: o_ready=1. Each accepted byte is written to buf[idx]; idx increments; count increments.
  - PAD: writes one byte per cycle at idx.
  - OUT: o_block_valid=1.
- LOAD transitions:
  - Byte accepted at idx 63 with no i_last: go to OUT, final=0.
  - i_last at idx<63: go to PAD at idx+1 with marker pending.
  - i_last at idx 63: go to OUT, final=0, with marker pending.
  - i_last & i_empty: no write, count unchanged; go to PAD at the current idx (0).
- PAD byte selection, in priority order:
  - Marker pending: write 0x80 and clear pending.
  - idx≥56 and length_sel: write length byte (idx-56) of the 64-bit big-endian bit length.
  - Otherwise: write 0x00.
- length_sel is decided at idx 56: it is 1 iff the marker was written before idx 56 in this block, or in an earlier block.
- At idx 63, PAD goes to OUT with final=length_sel.
- OUT, on i_block_ready:
  - final=1: go to LOAD; idx, count and flags clear.
  - final=0 and the message has ended (last seen): go to PAD at idx 0.
  - Otherwise: go to LOAD at idx 0.
- The buffer is not cleared between blocks; every byte position is rewritten before OUT.
- Count overflow wraps modulo 2^LEN_BYTES_W. No error is flagged.

## Timing
- Reset values:
  - State is LOAD, so o_ready=1.
  - o_block_valid=0 and o_block_last=0.
  - All o_w*=0; idx=0, count=0, flags clear.
  - Bytes presented while i_reset=1 are discarded.
- Reset mid-message or mid-block discards all partial state. o_block_valid drops on the cycle after reset is sampled.
- Throughput is one byte per cycle in LOAD and one pad byte per cycle in PAD.
- Registered outputs: o_block_valid rises on the cycle after the idx-63 write.
- Latency: if the last byte is accepted at idx p<63, o_block_valid rises 64-p cycles after acceptance.
- Hold rule: while o_block_valid=1 and i_block_ready=0, o_w* and o_block_last are stable.
- o_ready=0 in PAD and OUT.
- No combinational path from i_block_ready to o_ready. o_ready returns one cycle after the handshake.

## Structure
- Package sha256_pkg holds:
  - the state enum (LOAD, PAD, OUT);
  - BLOCK_BYTES=64;
  - LEN_POS=56;
  - PAD_MARKER=8'h80.
- Sub-module sha256_block_buf: a 64×8 byte buffer with a single write port (addr, data, we) and a 512-bit flat read out, mapped to the 16 words.

## Test plan
- "abc" (0x61,0x62,0x63, last on 0x63): one block, o_block_last=1.
  - w0=0x61626380, w1–w14=0, w15=0x00000018.
  - o_block_valid on the 64th cycle after the first byte.
- Empty message (i_valid & i_last & i_empty): one block with w0=0x80000000, w1–w15=0, o_block_last=1.
- 55 bytes of 0x00: one block.
  - w13=0x00000080, w14=0, w15=0x000001B8.
- 56 bytes of 0x00: two blocks.
  - Block 1: w14=0x80000000, w15=0, last=0.
  - Block 2: w0–w14=0, w15=0x000001C0, last=1.
- 64 bytes of 0xFF: two blocks.
  - Block 1: all 0xFFFFFFFF, last=0.
  - Block 2: w0=0x80000000, w15=0x00000200, last=1.
- Back-pressure, then reset:
  - Hold i_block_ready=0 for 10 cycles on the "abc" block: outputs stable, o_ready=0.
  - Then assert i_reset mid-way through a following 20-byte message: o_block_valid=0 and o_ready=1 the next cycle.
  - Re-sending "abc" yields the first scenario's words.
